// File: rtl/bsg_async_ptr_gray_reader.sv
// bsg_async_ptr_gray_reader
// Read-side pointer controller for a gray-coded asynchronous FIFO. Lives
// entirely in the read clock domain: decodes the synchronized gray write
// pointer, owns the binary/gray read pointers, and derives occupancy/valid.
//
// Optional feature: define BSG_ASYNC_PTR_GRAY_READER_UNDERFLOW_EN to build a
// sticky dequeue-while-empty flag on r_underflow_o. Without it the output is
// tied low and no flop is built.
module bsg_async_ptr_gray_reader #(
  parameter int lg_size_p = 6
) (
  input  logic                 r_clk_i,
  input  logic                 r_reset_n_i,
  input  logic [lg_size_p-1:0] w_ptr_gray_rsync_i,
  input  logic                 r_deq_i,
  output logic                 r_valid_o,
  output logic [lg_size_p-1:0] r_count_o,
  output logic [lg_size_p-1:0] r_ptr_binary_r_o,
  output logic [lg_size_p-1:0] r_ptr_gray_r_o,
  output logic                 r_underflow_o
);

  localparam logic [lg_size_p-1:0] one_lp = lg_size_p'(1);

  function automatic logic [lg_size_p-1:0] gray_to_bin(input logic [lg_size_p-1:0] g);
    logic [lg_size_p-1:0] b;
    b[lg_size_p-1] = g[lg_size_p-1];
    for (int i = lg_size_p-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [lg_size_p-1:0] bin_to_gray(input logic [lg_size_p-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [lg_size_p-1:0] w_ptr_binary_q, w_ptr_binary_d;
  logic [lg_size_p-1:0] r_ptr_binary_q, r_ptr_binary_d;
  logic [lg_size_p-1:0] r_ptr_gray_q,   r_ptr_gray_d;
  logic [lg_size_p-1:0] r_ptr_inc;
  logic [lg_size_p-1:0] count;
  logic                 valid;
  logic                 deq_v;

  // Occupancy and accept: modular difference handles pointer wrap-around.
  always_comb begin
    count     = w_ptr_binary_q - r_ptr_binary_q;
    valid     = (count != '0);
    deq_v     = r_deq_i & valid;
    r_ptr_inc = r_ptr_binary_q + one_lp;
  end

  // Next-state: decode write pointer every cycle; advance read pointers on accept.
  always_comb begin
    w_ptr_binary_d = gray_to_bin(w_ptr_gray_rsync_i);
    r_ptr_binary_d = r_ptr_binary_q;
    r_ptr_gray_d   = r_ptr_gray_q;
    if (deq_v) begin
      r_ptr_binary_d = r_ptr_inc;
      r_ptr_gray_d   = bin_to_gray(r_ptr_inc);
    end
  end

  // Pointer registers; the gray pointer leaves the block straight from its flop.
  always_ff @(posedge r_clk_i) begin
    if (!r_reset_n_i) begin
      w_ptr_binary_q <= '0;
      r_ptr_binary_q <= '0;
      r_ptr_gray_q   <= '0;
    end else begin
      w_ptr_binary_q <= w_ptr_binary_d;
      r_ptr_binary_q <= r_ptr_binary_d;
      r_ptr_gray_q   <= r_ptr_gray_d;
    end
  end

`ifdef BSG_ASYNC_PTR_GRAY_READER_UNDERFLOW_EN
  logic underflow_q, underflow_d;

  // Sticky flag: any dequeue request seen while empty latches until reset.
  always_comb begin
    underflow_d = underflow_q | (r_deq_i & ~valid);
  end

  // Underflow register.
  always_ff @(posedge r_clk_i) begin
    if (!r_reset_n_i) begin
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= underflow_d;
    end
  end

  assign r_underflow_o = underflow_q;
`else
  assign r_underflow_o = 1'b0;
`endif

  assign r_valid_o        = valid;
  assign r_count_o        = count;
  assign r_ptr_binary_r_o = r_ptr_binary_q;
  assign r_ptr_gray_r_o   = r_ptr_gray_q;

endmodule

// File: tb/tb_bsg_async_ptr_gray_reader.sv
// Testbench for bsg_async_ptr_gray_reader: directed scenarios followed by a
// randomized run, all checked against a reference model that tracks total
// items written and read as plain integers.
module tb_bsg_async_ptr_gray_reader;

  localparam int LG    = 6;
  localparam int MODV  = 1 << LG;
  localparam int DEPTH = 1 << (LG - 1);

  logic          clk;
  logic          rst_n;
  logic [LG-1:0] w_gray;
  logic          deq;
  logic          valid;
  logic [LG-1:0] count;
  logic [LG-1:0] rptr_bin;
  logic [LG-1:0] rptr_gray;
  logic          uf;

  int n_tests;
  int n_fail;

  // Reference model state
  int wr_total;   // absolute number of items the writer has published
  int w_seen;     // write total as visible to the reader (one edge late)
  int rd_total;   // absolute number of items dequeued since reset
  int exp_uf;

  bsg_async_ptr_gray_reader #(.lg_size_p(LG)) dut (
    .r_clk_i           (clk),
    .r_reset_n_i       (rst_n),
    .w_ptr_gray_rsync_i(w_gray),
    .r_deq_i           (deq),
    .r_valid_o         (valid),
    .r_count_o         (count),
    .r_ptr_binary_r_o  (rptr_bin),
    .r_ptr_gray_r_o    (rptr_gray),
    .r_underflow_o     (uf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mmod(input int x);
    return ((x % MODV) + MODV) % MODV;
  endfunction

  function automatic int to_gray(input int x);
    int b;
    b = mmod(x);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock edge: advance the model, then compare every output.
  task automatic step();
    int occ;
    w_gray = LG'(to_gray(wr_total));
    @(posedge clk);
    occ = mmod(w_seen - rd_total);
    if (!rst_n) begin
      rd_total = 0;
      w_seen   = 0;
      exp_uf   = 0;
    end else begin
`ifdef BSG_ASYNC_PTR_GRAY_READER_UNDERFLOW_EN
      if (deq && occ == 0) exp_uf = 1;
`endif
      if (deq && occ != 0) rd_total++;
      w_seen = wr_total;
    end
    #1;
    chk("count", int'(count), mmod(w_seen - rd_total));
    chk("valid", int'(valid), (mmod(w_seen - rd_total) != 0) ? 1 : 0);
    chk("rptr_bin", int'(rptr_bin), mmod(rd_total));
    chk("rptr_gray", int'(rptr_gray), to_gray(rd_total));
    chk("underflow", int'(uf), exp_uf);
  endtask

  initial begin
    int guard;
    n_tests  = 0;
    n_fail   = 0;
    rd_total = 0;
    w_seen   = 0;
    exp_uf   = 0;
    deq      = 1'b0;
    rst_n    = 1'b0;
    wr_total = 2;                    // drives gray 6'b000011
    w_gray   = LG'(to_gray(wr_total));
    #2;

    // Reset held two cycles with a nonzero write pointer
    step();
    step();
    rst_n = 1'b1;
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_ptr", int'(rptr_bin), 0);
    chk("rst_gray", int'(rptr_gray), 0);
    chk("rst_uf", int'(uf), 0);
    step();
    chk("rst_then_count", int'(count), 2);
    chk("rst_then_valid", int'(valid), 1);

    // Fill to 5, then drain with six dequeues
    rst_n = 1'b0; wr_total = 0; step(); rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      wr_total = k;
      step();
    end
    chk("fill_count", int'(count), 5);
    deq = 1'b1;
    for (int k = 0; k < 6; k++) step();
    deq = 1'b0;
    chk("drain_count", int'(count), 0);
    chk("drain_ptr", int'(rptr_bin), 5);
    chk("drain_gray", int'(rptr_gray), 7);
    step();
    chk("drain_hold", int'(count), 0);

    // Simultaneous write advance and dequeue at count 3
    wr_total = 8; step();
    chk("sim_pre", int'(count), 3);
    wr_total = 9; deq = 1'b1; step(); deq = 1'b0;
    chk("sim_count", int'(count), 3);
    chk("sim_ptr", int'(rptr_bin), 6);

    // Walk read pointer to 63, then wrap write pointer to 0
    deq   = 1'b1;
    guard = 0;
    while (rd_total < MODV - 1 && guard < 200) begin
      wr_total = (rd_total + 20 < MODV - 1) ? rd_total + 20 : MODV - 1;
      step();
      guard++;
    end
    deq = 1'b0;
    chk("wrap_reach", rd_total, MODV - 1);
    wr_total = MODV - 1; step();
    wr_total = MODV;     step();
    chk("wrap_count", int'(count), 1);
    chk("wrap_ptr_pre", int'(rptr_bin), MODV - 1);
    deq = 1'b1; step(); deq = 1'b0;
    chk("wrap_ptr", int'(rptr_bin), 0);
    chk("wrap_gray", int'(rptr_gray), 0);
    chk("wrap_empty", int'(count), 0);

    // Dequeue while empty
    deq = 1'b1; step(); deq = 1'b0;
    step();
`ifdef BSG_ASYNC_PTR_GRAY_READER_UNDERFLOW_EN
    chk("uf_sticky", int'(uf), 1);
`else
    chk("uf_tied", int'(uf), 0);
`endif
    chk("uf_ptr_hold", int'(rptr_bin), 0);

    // Reset mid-operation with count 4 and dequeue asserted
    wr_total = MODV + 4; step();
    chk("mid_pre", int'(count), 4);
    rst_n = 1'b0; deq = 1'b1; step();
    chk("mid_count", int'(count), 0);
    chk("mid_ptr", int'(rptr_bin), 0);
    chk("mid_uf", int'(uf), 0);
    rst_n = 1'b1; deq = 1'b0; step();
    deq = 1'b1; step(); deq = 1'b0;
    chk("mid_resume", int'(rptr_bin), 1);

    // Randomized traffic with occasional resets
    rst_n = 1'b0; wr_total = 0; step(); rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_n    = 1'b0;
        wr_total = int'($urandom_range(0, 3));
      end else begin
        rst_n = 1'b1;
        wr_total = wr_total + int'($urandom_range(0, 3));
        if (wr_total > rd_total + DEPTH) wr_total = rd_total + DEPTH;
      end
      deq = ($urandom_range(0, 99) < 55);
      step();
    end
    deq = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
